led_frame_rx: RTL and testbench

- Serial-frame receiver for the LED driver chain; it receives the SDO/SCLK/LAT stream that our LED shift controller drives.
- Oversamples SCLK/LAT on its own clock and deserialises each channel's 48-bit colour triplets ({B16,G16,R16}).
- Checks the per-device latch-select bit and overall frame length, then reports each triplet and frame completion.
- Used as a loopback checker on the FPGA and as a TLC5955-chain model in system benches.

---
 rtl/led_frame_rx.sv | 208 ++++++++++++++++++++
 tb/tb_led_frame_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_rx.sv
// led_frame_rx: oversampling receiver for the LED driver serial chain.
// Each SCLK rise carries one bit on every SDIs line. A frame per channel is
// NUM_DEVICES segments of {select bit, WORDS_PER_DEVICE x 48-bit triplet},
// closed by a LAT rise. Triplets are reported as they complete; the frame is
// reported as done (well formed) or errored (bad select bit, short, overrun).
//
// Ports:
//   spiClk     sole clock, rising edge
//   nReset     asynchronous active-low reset
//   SDIs       serial data, one line per channel (asynchronous)
//   SCLK       serial clock (asynchronous), data taken on its rising edge
//   LAT        latch strobe (asynchronous), rising edge ends the frame
//   wordValid  one-cycle pulse, wordData/wordIdx valid
//   wordData   channel c at [c*48 +: 48], first-received bit in bit 47
//   wordIdx    triplet index within the frame
//   frameDone  one-cycle pulse, well-formed frame latched
//   frameErr   one-cycle pulse, malformed frame
//   busy       high while a frame is being received
module led_frame_rx #(
    parameter int unsigned NUM_SHIFT_CHANNEL = 4,
    parameter int unsigned NUM_DEVICES       = 2,
    parameter int unsigned WORDS_PER_DEVICE  = 16,
    parameter logic        EXPECT_SEL        = 1'b0,
    localparam int unsigned NumWords = NUM_DEVICES * WORDS_PER_DEVICE,
    localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned DataW    = NUM_SHIFT_CHANNEL * 48
) (
    input  logic                         spiClk,
    input  logic                         nReset,
    input  logic [NUM_SHIFT_CHANNEL-1:0] SDIs,
    input  logic                         SCLK,
    input  logic                         LAT,
    output logic                         wordValid,
    output logic [DataW-1:0]             wordData,
    output logic [IdxW-1:0]              wordIdx,
    output logic                         frameDone,
    output logic                         frameErr,
    output logic                         busy
);

    localparam int unsigned DevW  = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
    localparam int unsigned WordW = (WORDS_PER_DEVICE > 1) ? $clog2(WORDS_PER_DEVICE) : 1;

    typedef enum logic [2:0] {StIdle, StSel, StData, StWaitLat, StDrop} state_e;

    // Synchronisers plus one delay stage for edge detection.
    logic [2:0]                   sclk_sync_q;
    logic [2:0]                   lat_sync_q;
    logic [NUM_SHIFT_CHANNEL-1:0] sdi_meta_q, sdi_sync_q;
    // Registered detect cycle: rise flags and the data sampled with them.
    logic                         sclk_rise_q, lat_rise_q;
    logic [NUM_SHIFT_CHANNEL-1:0] sdi_smp_q;

    state_e           state_q, state_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [WordW-1:0] word_cnt_q, word_cnt_d;
    logic [DevW-1:0]  dev_cnt_q, dev_cnt_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [DataW-1:0] shift_q, shift_d, shift_nxt;
    logic [DataW-1:0] word_data_q, word_data_d;
    logic [IdxW-1:0]  word_idx_q, word_idx_d;
    logic             word_valid_q, word_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic             sel_ok;

    always_ff @(posedge spiClk or negedge nReset) begin
        if (!nReset) begin
            sclk_sync_q <= '0;
            lat_sync_q  <= '0;
            sdi_meta_q  <= '0;
            sdi_sync_q  <= '0;
            sclk_rise_q <= 1'b0;
            lat_rise_q  <= 1'b0;
            sdi_smp_q   <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
            lat_sync_q  <= {lat_sync_q[1:0], LAT};
            sdi_meta_q  <= SDIs;
            sdi_sync_q  <= sdi_meta_q;
            sclk_rise_q <= sclk_sync_q[1] & ~sclk_sync_q[2];
            lat_rise_q  <= lat_sync_q[1] & ~lat_sync_q[2];
            sdi_smp_q   <= sdi_sync_q;
        end
    end

    assign sel_ok = (sdi_smp_q == {NUM_SHIFT_CHANNEL{EXPECT_SEL}});

    always_comb begin
        shift_nxt = '0;
        for (int c = 0; c < NUM_SHIFT_CHANNEL; c++) begin
            shift_nxt[c*48 +: 48] = {shift_q[c*48 +: 47], sdi_smp_q[c]};
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        dev_cnt_d    = dev_cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        word_data_d  = word_data_q;
        word_idx_d   = word_idx_q;
        word_valid_d = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        busy_d       = busy_q;

        // LAT has priority over a coincident SCLK rise.
        if (lat_rise_q) begin
            if (state_q != StIdle) begin
                busy_d     = 1'b0;
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                dev_cnt_d  = '0;
                idx_d      = '0;
                state_d    = StIdle;
            end
            if (state_q == StWaitLat) begin
                frame_done_d = 1'b1;
            end else if (state_q == StSel || state_q == StData) begin
                frame_err_d = 1'b1;
            end
        end else if (sclk_rise_q) begin
            unique case (state_q)
                StIdle, StSel: begin
                    busy_d = 1'b1;
                    if (sel_ok) begin
                        state_d = StData;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StDrop;
                    end
                end
                StData: begin
                    shift_d = shift_nxt;
                    if (bit_cnt_q == 6'd47) begin
                        bit_cnt_d    = '0;
                        word_data_d  = shift_nxt;
                        word_idx_d   = idx_q;
                        word_valid_d = 1'b1;
                        idx_d        = idx_q + IdxW'(1);
                        if (word_cnt_q == WordW'(WORDS_PER_DEVICE - 1)) begin
                            word_cnt_d = '0;
                            if (dev_cnt_q == DevW'(NUM_DEVICES - 1)) begin
                                state_d = StWaitLat;
                            end else begin
                                dev_cnt_d = dev_cnt_q + DevW'(1);
                                state_d   = StSel;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + WordW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                StWaitLat: begin
                    frame_err_d = 1'b1;
                    state_d     = StDrop;
                end
                StDrop: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge spiClk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            dev_cnt_q    <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            word_data_q  <= '0;
            word_idx_q   <= '0;
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            dev_cnt_q    <= dev_cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            word_data_q  <= word_data_d;
            word_idx_q   <= word_idx_d;
            word_valid_q <= word_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign wordValid = word_valid_q;
    assign wordData  = word_data_q;
    assign wordIdx   = word_idx_q;
    assign frameDone = frame_done_q;
    assign frameErr  = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_led_frame_rx.sv
// tb_led_frame_rx: drives serial frames into led_frame_rx and compares the
// reported triplets and frame outcome against a bit-position model of the
// frame format (device = pos / segment, select bit at segment offset 0).
module tb_led_frame_rx;

    localparam int NCH   = 4;
    localparam int ND    = 2;
    localparam int NW    = 16;
    localparam int SEG   = 1 + NW * 48;
    localparam int TOTAL = ND * SEG;
    localparam logic [NCH-1:0] SEL_WORD = '0;

    logic             spiClk;
    logic             nReset;
    logic [NCH-1:0]   SDIs;
    logic             SCLK;
    logic             LAT;
    logic             wordValid;
    logic [NCH*48-1:0] wordData;
    logic [4:0]       wordIdx;
    logic             frameDone;
    logic             frameErr;
    logic             busy;

    led_frame_rx #(
        .NUM_SHIFT_CHANNEL(NCH),
        .NUM_DEVICES      (ND),
        .WORDS_PER_DEVICE (NW),
        .EXPECT_SEL       (1'b0)
    ) dut (
        .spiClk   (spiClk),
        .nReset   (nReset),
        .SDIs     (SDIs),
        .SCLK     (SCLK),
        .LAT      (LAT),
        .wordValid(wordValid),
        .wordData (wordData),
        .wordIdx  (wordIdx),
        .frameDone(frameDone),
        .frameErr (frameErr),
        .busy     (busy)
    );

    initial spiClk = 1'b0;
    always #5 spiClk = ~spiClk;

    int n_checks = 0;
    int n_errors = 0;

    logic [NCH-1:0]    stim_q[$];
    int                exp_idx[$];
    logic [NCH*48-1:0] exp_data[$];
    int                exp_done, exp_err;
    bit                exp_drop;

    int                got_idx[$];
    logic [NCH*48-1:0] got_data[$];
    int                got_done, got_err;

    task automatic check_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge spiClk) begin
        if (nReset) begin
            if (wordValid) begin
                got_idx.push_back(int'(wordIdx));
                got_data.push_back(wordData);
            end
            if (frameDone) got_done++;
            if (frameErr) got_err++;
        end
    end

    task automatic clear_mon();
        got_idx.delete();
        got_data.delete();
        got_done = 0;
        got_err  = 0;
    endtask

    // Reference model: walks bit positions of the frame format.
    task automatic model_frame();
        bit                dropped;
        logic [NCH*48-1:0] acc;
        int                dev, off, w, b;
        dropped = 0;
        acc     = '0;
        exp_idx.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err  = 0;
        for (int p = 0; p < stim_q.size(); p++) begin
            if (!dropped) begin
                if (p >= TOTAL) begin
                    exp_err++;
                    dropped = 1;
                end else begin
                    dev = p / SEG;
                    off = p % SEG;
                    if (off == 0) begin
                        if (stim_q[p] != SEL_WORD) begin
                            exp_err++;
                            dropped = 1;
                        end
                    end else begin
                        w = (off - 1) / 48;
                        b = (off - 1) % 48;
                        for (int c = 0; c < NCH; c++) acc[c*48 + 47 - b] = stim_q[p][c];
                        if (b == 47) begin
                            exp_idx.push_back(dev * NW + w);
                            exp_data.push_back(acc);
                        end
                    end
                end
            end
        end
        exp_drop = dropped;
        if (!dropped) begin
            if (stim_q.size() == TOTAL) exp_done++;
            else if (stim_q.size() > 0) exp_err++;
        end
    endtask

    function automatic logic [NCH*48-1:0] gen_word(input int mode, input int n);
        logic [NCH*48-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) begin
            case (mode)
                0:       v[c*48 +: 48] = 48'hFFFF_FFFF_FFFF;
                1:       v[c*48 +: 48] = {16'(16'hB000 + n), 16'(16'h6000 + c), 16'(16'hA000 + n)};
                default: v[c*48 +: 48] = {16'($urandom), 32'($urandom)};
            endcase
        end
        return v;
    endfunction

    task automatic build_full(input int mode, input logic [NCH-1:0] sel1);
        logic [NCH*48-1:0] wd;
        logic [NCH-1:0]    bits;
        stim_q.delete();
        for (int d = 0; d < ND; d++) begin
            stim_q.push_back((d == 1) ? sel1 : SEL_WORD);
            for (int w = 0; w < NW; w++) begin
                wd = gen_word(mode, d * NW + w);
                for (int b = 0; b < 48; b++) begin
                    for (int c = 0; c < NCH; c++) bits[c] = wd[c*48 + 47 - b];
                    stim_q.push_back(bits);
                end
            end
        end
    endtask

    // Low 3 cycles (data changes 2 cycles before the rise), high 2 cycles.
    task automatic send_bit(input logic [NCH-1:0] b);
        @(negedge spiClk) SCLK = 1'b0;
        @(negedge spiClk) SDIs = b;
        @(negedge spiClk);
        @(negedge spiClk) SCLK = 1'b1;
        @(negedge spiClk);
    endtask

    task automatic send_lat();
        @(negedge spiClk) SCLK = 1'b0;
        repeat (3) @(negedge spiClk);
        LAT = 1'b1;
        repeat (3) @(negedge spiClk);
        LAT = 1'b0;
        repeat (8) @(negedge spiClk);
    endtask

    task automatic compare_words(input string tag);
        int n;
        check_val({tag, ".nwords"}, 192'(got_idx.size()), 192'(exp_idx.size()));
        n = (got_idx.size() < exp_idx.size()) ? got_idx.size() : exp_idx.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s.idx%0d", tag, i), 192'(got_idx[i]), 192'(exp_idx[i]));
            check_val($sformatf("%s.data%0d", tag, i), got_data[i], exp_data[i]);
        end
    endtask

    task automatic run_frame(input string tag);
        model_frame();
        clear_mon();
        foreach (stim_q[i]) send_bit(stim_q[i]);
        repeat (8) @(negedge spiClk);
        if (!exp_drop && stim_q.size() > 0) check_val({tag, ".busy_pre"}, 192'(busy), 192'(1));
        send_lat();
        compare_words(tag);
        check_val({tag, ".done"}, 192'(got_done), 192'(exp_done));
        check_val({tag, ".err"}, 192'(got_err), 192'(exp_err));
        check_val({tag, ".busy_post"}, 192'(busy), 192'(0));
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".wordValid"}, 192'(wordValid), 192'(0));
        check_val({tag, ".frameDone"}, 192'(frameDone), 192'(0));
        check_val({tag, ".frameErr"}, 192'(frameErr), 192'(0));
        check_val({tag, ".busy"}, 192'(busy), 192'(0));
        check_val({tag, ".wordData"}, wordData, 192'(0));
        check_val({tag, ".wordIdx"}, 192'(wordIdx), 192'(0));
    endtask

    initial begin
        nReset = 1'b0;
        SDIs   = '0;
        SCLK   = 1'b0;
        LAT    = 1'b0;
        clear_mon();
        repeat (4) @(negedge spiClk);
        check_zero("reset");
        nReset = 1'b1;
        repeat (4) @(negedge spiClk);

        build_full(0, SEL_WORD);
        run_frame("ones");

        build_full(1, SEL_WORD);
        run_frame("indexed");

        // 20 full words plus 10 bits: two select bits are included.
        build_full(2, SEL_WORD);
        while (stim_q.size() > 2 + 20 * 48 + 10) void'(stim_q.pop_back());
        run_frame("short");

        build_full(2, SEL_WORD);
        run_frame("rand_after_short");

        build_full(2, 4'b0100);
        run_frame("sel_err");

        build_full(2, SEL_WORD);
        stim_q.push_back(4'(($urandom)));
        run_frame("overrun");

        stim_q.delete();
        run_frame("lat_idle");

        // Reset in the middle of word 5.
        build_full(2, SEL_WORD);
        clear_mon();
        for (int i = 0; i < 1 + 5 * 48 + 20; i++) send_bit(stim_q[i]);
        repeat (8) @(negedge spiClk);
        check_val("midreset.nwords_before", 192'(got_idx.size()), 192'(5));
        #2;
        nReset = 1'b0;
        #1;
        check_zero("midreset");
        SCLK = 1'b0;
        repeat (4) @(negedge spiClk);
        nReset = 1'b1;
        repeat (4) @(negedge spiClk);
        build_full(2, SEL_WORD);
        run_frame("after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
